serial_alu_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (AND/OR/ADD with A/B invert + carry-in).

---
 rtl/serial_alu_pkg.sv | 40 ++++
 rtl/alu_bit_slice.sv | 31 +++
 rtl/serial_alu_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: opcodes, sequencer states and the
// per-op control word that configures the 1-bit slice.
package serial_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] operation;
    logic       cin0;
  } slice_ctrl_t;

  // Illegal opcodes select slice operation 11, which forces a zero result.
  function automatic slice_ctrl_t op_to_ctrl(input logic [2:0] op);
    slice_ctrl_t c;
    case (op)
      OP_AND:  c = '{ainv: 1'b0, binv: 1'b0, operation: 2'b00, cin0: 1'b0};
      OP_OR:   c = '{ainv: 1'b0, binv: 1'b0, operation: 2'b01, cin0: 1'b0};
      OP_ADD:  c = '{ainv: 1'b0, binv: 1'b0, operation: 2'b10, cin0: 1'b0};
      OP_SUB:  c = '{ainv: 1'b0, binv: 1'b1, operation: 2'b10, cin0: 1'b1};
      OP_NOR:  c = '{ainv: 1'b1, binv: 1'b1, operation: 2'b00, cin0: 1'b0};
      OP_NAND: c = '{ainv: 1'b1, binv: 1'b1, operation: 2'b01, cin0: 1'b0};
      default: c = '{ainv: 1'b0, binv: 1'b0, operation: 2'b11, cin0: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, then AND / OR /
// full-add selected by operation; operation 11 yields 0.
module alu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       ainv,
  input  logic       binv,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainv;
  assign bb   = b ^ binv;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    result = 1'b0;
    case (operation)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = aa ^ bb ^ cin;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: runs one ALU slice LSB-first over WIDTH cycles with a
// registered carry loop, then reports result and flags with a one-cycle done.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  slice_ctrl_t      ctrl_in;
  logic             ainv_r;
  logic             binv_r;
  logic [1:0]       oper_r;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry_r;
  logic             s_res;
  logic             s_cout;
  logic             accept;
  logic             arith;
  logic [WIDTH-1:0] res_next;

  assign ctrl_in  = op_to_ctrl(op);
  assign accept   = start & ~busy;
  assign arith    = (oper_r == 2'b10);
  assign res_next = {s_res, res_sh};

  alu_bit_slice u_slice (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .ainv      (ainv_r),
    .binv      (binv_r),
    .cin       (carry_r),
    .operation (oper_r),
    .result    (s_res),
    .cout      (s_cout)
  );

  // Datapath: operand shifters, result assembly and carry loop (no reset needed,
  // everything is reloaded on accept).
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      ainv_r  <= ctrl_in.ainv;
      binv_r  <= ctrl_in.binv;
      oper_r  <= ctrl_in.operation;
      carry_r <= ctrl_in.cin0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next[WIDTH-1:1];
      carry_r <= s_cout;
    end
  end

  // Control FSM with registered handshake and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt       <= '0;
            result    <= res_next;
            carry_out <= arith & s_cout;
            // carry_r holds the carry into the MSB while the MSB is in the slice
            overflow  <= arith & (carry_r ^ s_cout);
            zero      <= ~|res_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl (WIDTH=8): table of ops with hand-computed
// results, plus ignored-start, back-to-back and mid-op reset sequences.
module tb_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       zero;

  int errors = 0;
  int checks = 0;

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; accepts on the next edge, returns in the done cycle
  // (or after a bounded wait). lat counts cycles after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                        output int lat);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int ndone;

  initial begin
    vecs[0]  = '{"add_ovf",  3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"sub_eq",   3'b011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"sub_neg",  3'b011, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"and",      3'b000, 8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"or",       3'b001, 8'hC3, 8'hA5, 8'hE7, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"nor",      3'b100, 8'hC3, 8'hA5, 8'h18, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"nand",     3'b101, 8'hC3, 8'hA5, 8'h7E, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"ill110",   3'b110, 8'hC3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"ill111",   3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{"add_wrap", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"add_neg",  3'b010, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"sub_ovf",  3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry_out, overflow, zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_latency"}, lat, 9);
      check({vecs[i].name, "_result"}, result, vecs[i].res);
      check({vecs[i].name, "_carry"}, carry_out, vecs[i].c);
      check({vecs[i].name, "_ovf"}, overflow, vecs[i].v);
      check({vecs[i].name, "_zero"}, zero, vecs[i].z);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, done, 0);
    end

    // start during RUN is ignored
    op = 3'b010; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    op = 3'b000; a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      if (done) begin
        ndone++;
        check("ign_result", result, 8'h46);
      end
      @(posedge clk); #1;
    end
    check("ign_done_count", ndone, 1);
    check("ign_result_held", result, 8'h46);

    // Back-to-back: start held in the DONE cycle
    run_op(3'b001, 8'h0F, 8'hF0, lat);
    check("b2b_first_lat", lat, 9);
    check("b2b_first_res", result, 8'hFF);
    op = 3'b011; a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_no_gap", busy, 1);
    check("b2b_res_held", result, 8'hFF);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_second_lat", lat, 9);
    check("b2b_second_res", result, 8'h0F);
    check("b2b_second_carry", carry_out, 1);

    // Reset at bit 4 of an ADD
    @(posedge clk); #1;
    op = 3'b010; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", {done, carry_out, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    run_op(3'b010, 8'h7F, 8'h7F, lat);
    check("post_rst_lat", lat, 9);
    check("post_rst_res", result, 8'hFE);
    check("post_rst_ovf", overflow, 1);
    check("post_rst_carry", carry_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
